// File: rtl/nes_dma_pkg.sv
// NES-style OAM DMA shared definitions.
// State encoding and default bus addresses.
package nes_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

endpackage

// File: rtl/oam_dma_controller_if.sv
// CPU-side and DMA-side bus signals of the OAM DMA block.
// master = controller, slave = surrounding system.
interface oam_dma_controller_if;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic [7:0]  bus_din;
  logic        cpu_rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_we;

  modport master (
    input  cpu_addr,
    input  cpu_dout,
    input  cpu_we,
    input  bus_din,
    output cpu_rdy,
    output dma_active,
    output dma_addr,
    output dma_dout,
    output dma_we
  );

  modport slave (
    output cpu_addr,
    output cpu_dout,
    output cpu_we,
    output bus_din,
    input  cpu_rdy,
    input  dma_active,
    input  dma_addr,
    input  dma_dout,
    input  dma_we
  );

endinterface

// File: rtl/oam_dma_controller.sv
// OAM DMA: halts the CPU and copies one 256-byte page
// into the OAM data port, reads always on even cycles.
module oam_dma_controller
  import nes_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
  input logic            clk,
  input logic            rst,
  oam_dma_controller_if.master bus
);

  dma_state_t state;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data;
  logic       parity;

  logic       trig;

  assign trig = bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      page   <= 8'h00;
      idx    <= 8'h00;
      data   <= 8'h00;
      parity <= 1'b0;
    end else begin
      parity <= ~parity;
      unique case (state)
        IDLE: begin
          if (trig) begin
            page  <= bus.cpu_dout;
            idx   <= 8'h00;
            state <= HALT;
          end
        end
        // odd HALT cycle already lands READ on parity 0
        HALT:  state <= parity ? READ : ALIGN;
        ALIGN: state <= READ;
        READ: begin
          data  <= bus.bus_din;
          state <= WRITE;
        end
        WRITE: begin
          if (idx == 8'hFF) begin
            state <= IDLE;
          end else begin
            idx   <= idx + 8'h01;
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [15:0] addr_d;
  logic [7:0]  dout_d;
  logic        we_d;

  always_comb begin
    addr_d = 16'h0000;
    dout_d = 8'h00;
    we_d   = 1'b0;
    unique case (state)
      READ: addr_d = {page, idx};
      WRITE: begin
        addr_d = OAM_DATA_ADDR;
        dout_d = data;
        we_d   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.cpu_rdy    = (state == IDLE);
  assign bus.dma_active = (state != IDLE);
  assign bus.dma_addr   = addr_d;
  assign bus.dma_dout   = dout_d;
  assign bus.dma_we     = we_d;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller with a per-cycle
// scoreboard of expected DMA bus activity.
module tb_oam_dma_controller;

  localparam logic [1:0] K_HALT  = 2'd0;
  localparam logic [1:0] K_READ  = 2'd1;
  localparam logic [1:0] K_WRITE = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  dout;
  } exp_t;

  logic clk;
  logic rst;
  logic par;

  int tests;
  int fails;
  int act_cnt;
  int wcount;

  exp_t q[$];

  oam_dma_controller_if bus_i ();

  oam_dma_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
  );

  assign bus_i.bus_din = bus_i.dma_addr[7:0] ^ 8'h5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) par <= 1'b0;
    else      par <= ~par;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (bus_i.dma_active) begin
        act_cnt++;
        tests++;
        assert (q.size() != 0) else begin
          fails++;
          $error("FAIL extra_dma_cycle addr=%h we=%b expected none",
                 bus_i.dma_addr, bus_i.dma_we);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          tests++;
          assert ({bus_i.dma_addr, bus_i.dma_we, bus_i.dma_dout}
                  === {e.addr, e.we, e.dout}) else begin
            fails++;
            $error("FAIL bus got addr=%h we=%b dout=%h exp addr=%h we=%b dout=%h",
                   bus_i.dma_addr, bus_i.dma_we, bus_i.dma_dout,
                   e.addr, e.we, e.dout);
          end
          if (e.kind == K_READ) begin
            tests++;
            assert (par === 1'b0) else begin
              fails++;
              $error("FAIL read_parity got=%b exp=0 addr=%h", par, e.addr);
            end
          end
          if (e.kind == K_WRITE) wcount++;
        end
      end else begin
        tests++;
        assert ({bus_i.dma_addr, bus_i.dma_we, bus_i.dma_dout} === 25'h0)
        else begin
          fails++;
          $error("FAIL idle_outputs got addr=%h we=%b dout=%h exp 0/0/0",
                 bus_i.dma_addr, bus_i.dma_we, bus_i.dma_dout);
        end
      end
      tests++;
      assert (bus_i.cpu_rdy === !bus_i.dma_active) else begin
        fails++;
        $error("FAIL rdy_vs_active rdy=%b active=%b",
               bus_i.cpu_rdy, bus_i.dma_active);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // want_par: parity of the HALT cycle that follows the trigger
  task automatic trigger(input logic [7:0] page, input logic want_par,
                         output int len);
    exp_t e;
    @(posedge clk); #2;
    if (~par != want_par) begin
      @(posedge clk); #2;
    end
    act_cnt = 0;
    wcount  = 0;
    bus_i.cpu_we   = 1'b1;
    bus_i.cpu_addr = 16'h4014;
    bus_i.cpu_dout = page;
    e = '{kind: K_HALT, addr: 16'h0, we: 1'b0, dout: 8'h0};
    q.push_back(e);
    len = 1;
    if (~par == 1'b0) begin
      q.push_back(e);
      len++;
    end
    for (int i = 0; i < 256; i++) begin
      e = '{kind: K_READ, addr: {page, 8'(i)}, we: 1'b0, dout: 8'h0};
      q.push_back(e);
      e = '{kind: K_WRITE, addr: 16'h2004, we: 1'b1,
            dout: 8'(i) ^ 8'h5A};
      q.push_back(e);
      len += 2;
    end
    @(posedge clk); #2;
    bus_i.cpu_we   = 1'b0;
    bus_i.cpu_addr = 16'h0000;
    bus_i.cpu_dout = 8'h00;
  endtask

  task automatic wait_done(input string tag, input int len);
    int n;
    n = 0;
    while (n < 1000) begin
      @(negedge clk); #1;
      if (bus_i.cpu_rdy === 1'b1) break;
      n++;
    end
    check({tag, "_rdy"}, 32'(bus_i.cpu_rdy), 32'd1);
    check({tag, "_len"}, 32'(act_cnt), 32'(len));
    check({tag, "_q_empty"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int len;
    int n;
    tests = 0;
    fails = 0;
    act_cnt = 0;
    wcount = 0;
    rst = 1'b0;
    bus_i.cpu_we   = 1'b0;
    bus_i.cpu_addr = 16'h0000;
    bus_i.cpu_dout = 8'h00;

    #12;
    check("rst_rdy", 32'(bus_i.cpu_rdy), 32'd1);
    check("rst_active", 32'(bus_i.dma_active), 32'd0);
    check("rst_we", 32'(bus_i.dma_we), 32'd0);
    check("rst_addr", 32'(bus_i.dma_addr), 32'h0);
    rst = 1'b1;

    // foreign address write must do nothing
    @(posedge clk); #2;
    bus_i.cpu_we   = 1'b1;
    bus_i.cpu_addr = 16'h4015;
    bus_i.cpu_dout = 8'h02;
    @(posedge clk); #2;
    bus_i.cpu_we = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check("foreign_write", 32'(bus_i.dma_active), 32'd0);
    end

    trigger(8'h02, 1'b0, len);
    check("align_len", 32'(len), 32'd514);
    wait_done("p02_align", len);

    trigger(8'h02, 1'b1, len);
    check("noalign_len", 32'(len), 32'd513);
    wait_done("p02_noalign", len);

    trigger(8'h03, 1'b0, len);
    wait_done("p03_data", len);

    trigger(8'hFF, 1'b1, len);
    wait_done("pFF", len);
    repeat (4) begin
      @(negedge clk); #1;
      check("pFF_stay_idle", 32'(bus_i.dma_active), 32'd0);
    end

    // trigger during a transfer must be ignored
    trigger(8'h02, 1'b0, len);
    repeat (50) @(posedge clk);
    #2;
    bus_i.cpu_we   = 1'b1;
    bus_i.cpu_addr = 16'h4014;
    bus_i.cpu_dout = 8'h09;
    @(posedge clk); #2;
    bus_i.cpu_we   = 1'b0;
    bus_i.cpu_addr = 16'h0000;
    bus_i.cpu_dout = 8'h00;
    wait_done("midwrite", len);

    // asynchronous reset in the 100th WRITE
    trigger(8'h05, 1'b1, len);
    n = 0;
    while (n < 1000 && wcount < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("w100_reached", 32'(wcount), 32'd100);
    check("w100_we", 32'(bus_i.dma_we), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_rdy", 32'(bus_i.cpu_rdy), 32'd1);
    check("mid_rst_active", 32'(bus_i.dma_active), 32'd0);
    check("mid_rst_we", 32'(bus_i.dma_we), 32'd0);
    check("mid_rst_addr", 32'(bus_i.dma_addr), 32'h0);
    check("mid_rst_dout", 32'(bus_i.dma_dout), 32'h0);
    q.delete();
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check("post_rst_idle", 32'(bus_i.dma_active), 32'd0);
    end

    trigger(8'h07, 1'b0, len);
    wait_done("p07_after_rst", len);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
